// File: rtl/writeback_regfile.sv
// Writeback stage: EX/WB pipeline register, 32-entry register file commit, three read ports, retire counter.
// Define WB_BYPASS_EN to forward the committing WB result onto matching read ports in the same cycle.
module writeback_regfile #(
    parameter int DATA_W  = 128,
    parameter int INSTR_W = 25,
    parameter int REG_N   = 32,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 validEX,
    input  logic [INSTR_W-1:0]   instructionEX,
    input  logic [DATA_W-1:0]    resultEX,
    input  logic [4:0]           rs1Addr,
    input  logic [4:0]           rs2Addr,
    input  logic [4:0]           rs3Addr,
    output logic [DATA_W-1:0]    rs1Data,
    output logic [DATA_W-1:0]    rs2Data,
    output logic [DATA_W-1:0]    rs3Data,
    output logic [INSTR_W-1:0]   instructionWB,
    output logic [DATA_W-1:0]    rdWB,
    output logic                 validWB,
    output logic                 wbWriteEn,
    output logic [CNT_W-1:0]     retireCount
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               vld_q, vld_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic [DATA_W-1:0]  regs_q [REG_N];
    logic [4:0]         rd_addr;

    // Only R3 encodings with a zero opcode (nop) leave rd untouched.
    function automatic logic writes_rd(input logic [9:0] hi);
        if (!hi[9])
            return 1'b1;
        else if (!hi[8])
            return 1'b1;
        else
            return hi[7:0] != 8'h00;
    endfunction

    assign rd_addr   = instr_q[4:0];
    assign wbWriteEn = vld_q & writes_rd(instr_q[24:15]) & ~stall;

    always_comb begin
        instr_d  = instr_q;
        res_d    = res_q;
        vld_d    = vld_q;
        retire_d = retire_q;
        if (!stall) begin
            instr_d = instructionEX;
            res_d   = resultEX;
            vld_d   = validEX;
            if (vld_q)
                retire_d = retire_q + CNT_W'(1);
        end
    end

    // EX -> WB boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            res_q    <= '0;
            vld_q    <= 1'b0;
            retire_q <= '0;
        end else begin
            instr_q  <= instr_d;
            res_q    <= res_d;
            vld_q    <= vld_d;
            retire_q <= retire_d;
        end
    end

    // WB -> register file commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++)
                regs_q[i] <= '0;
        end else if (wbWriteEn) begin
            regs_q[rd_addr] <= res_q;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1Data = (wbWriteEn && rs1Addr == rd_addr) ? res_q : regs_q[rs1Addr];
    assign rs2Data = (wbWriteEn && rs2Addr == rd_addr) ? res_q : regs_q[rs2Addr];
    assign rs3Data = (wbWriteEn && rs3Addr == rd_addr) ? res_q : regs_q[rs3Addr];
`else
    assign rs1Data = regs_q[rs1Addr];
    assign rs2Data = regs_q[rs2Addr];
    assign rs3Data = regs_q[rs3Addr];
`endif

    assign instructionWB = instr_q;
    assign rdWB          = res_q;
    assign validWB       = vld_q;
    assign retireCount   = retire_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: retirement-level model checked every cycle, plus directed literal checks.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_writeback_regfile;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         stall = 1'b0;
    logic         validEX = 1'b0;
    logic [24:0]  instructionEX = '0;
    logic [127:0] resultEX = '0;
    logic [4:0]   rs1Addr = '0, rs2Addr = '0, rs3Addr = '0;
    logic [127:0] rs1Data, rs2Data, rs3Data, rdWB;
    logic [24:0]  instructionWB;
    logic         validWB, wbWriteEn;
    logic [31:0]  retireCount;

    logic [127:0] w_rs1, w_rs2, w_rs3, w_rd;
    logic [24:0]  w_instr;
    logic         w_vld, w_we;
    logic [3:0]   w_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .validEX(validEX),
        .instructionEX(instructionEX), .resultEX(resultEX),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs3Addr(rs3Addr),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .rs3Data(rs3Data),
        .instructionWB(instructionWB), .rdWB(rdWB), .validWB(validWB),
        .wbWriteEn(wbWriteEn), .retireCount(retireCount)
    );

    writeback_regfile #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall(stall), .validEX(validEX),
        .instructionEX(instructionEX), .resultEX(resultEX),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs3Addr(rs3Addr),
        .rs1Data(w_rs1), .rs2Data(w_rs2), .rs3Data(w_rs3),
        .instructionWB(w_instr), .rdWB(w_rd), .validWB(w_vld),
        .wbWriteEn(w_we), .retireCount(w_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state: the instruction occupying WB, the architectural registers, retired count.
    logic [24:0]  m_instr;
    logic [127:0] m_res;
    logic         m_vld;
    logic [31:0]  m_cnt;
    logic [127:0] m_regs [32];

    function automatic bit tb_writes(input logic [24:0] ins);
        case (ins[24:23])
            2'b11:   return ins[22:15] != 8'h00;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_instr <= '0;
            m_res   <= '0;
            m_vld   <= 1'b0;
            m_cnt   <= '0;
            for (int i = 0; i < 32; i++)
                m_regs[i] <= '0;
        end else if (!stall) begin
            if (m_vld) begin
                m_cnt <= m_cnt + 1;
                if (tb_writes(m_instr))
                    m_regs[m_instr[4:0]] <= m_res;
            end
            m_instr <= instructionEX;
            m_res   <= resultEX;
            m_vld   <= validEX;
        end
    end

    function automatic logic [127:0] exp_read(input logic [4:0] a);
        logic [127:0] v;
        v = m_regs[a];
`ifdef WB_BYPASS_EN
        if (m_vld && tb_writes(m_instr) && !stall && a == m_instr[4:0])
            v = m_res;
`endif
        return v;
    endfunction

    always begin
        @(posedge clk);
        #2;
        if (chk_en) begin
            check("instructionWB", instructionWB, m_instr);
            check("rdWB", rdWB, m_res);
            check("validWB", validWB, m_vld);
            check("wbWriteEn", wbWriteEn, m_vld && tb_writes(m_instr) && !stall);
            check("retireCount", retireCount, m_cnt);
            check("retireCount4", w_cnt, m_cnt[3:0]);
            check("rs1Data", rs1Data, exp_read(rs1Addr));
            check("rs2Data", rs2Data, exp_read(rs2Addr));
            check("rs3Data", rs3Data, exp_read(rs3Addr));
        end
    end

    // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
    task automatic cyc(input logic [24:0] ins, input logic [127:0] res, input logic v, input logic st);
        instructionEX = ins;
        resultEX      = res;
        validEX       = v;
        stall         = st;
        @(negedge clk);
    endtask

    localparam logic [24:0] I_ADD25 = 25'b1100000001011001000111001;
    localparam logic [24:0] I_LI1   = 25'h0000001;
    localparam logic [24:0] I_LI5   = 25'h0000005;
    localparam logic [24:0] I_R3_7  = {2'b11, 8'h01, 10'h0, 5'd7};
    localparam logic [24:0] I_NOP3  = {2'b11, 8'h00, 10'h0, 5'd3};
    localparam logic [24:0] I_R4_9  = {2'b10, 8'h44, 10'h0, 5'd9};

    logic [127:0] exp_byp;
    logic [127:0] v_stall;
    logic [31:0]  c0;

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_instructionWB", instructionWB, 25'h0);
        check("rst_retireCount", retireCount, 32'h0);
        check("rst_validWB", validWB, 1'b0);
        rst_n = 1'b1;

        // Basic commit, two-edge latency
        cyc(I_ADD25, {4{32'h6}}, 1'b1, 1'b0);
        check("basic_instrWB", instructionWB, I_ADD25);
        check("basic_rdWB", rdWB, {4{32'h6}});
        check("basic_we", wbWriteEn, 1'b1);
        rs1Addr = 5'd25;
        cyc('0, '0, 1'b0, 1'b0);
        check("basic_rs1", rs1Data, {4{32'h6}});
        check("basic_count", retireCount, 32'd1);

        // Same-cycle read of the register being committed
        rs3Addr = 5'd1;
        cyc(I_LI1, {16{8'hA5}}, 1'b1, 1'b0);
`ifdef WB_BYPASS_EN
        exp_byp = {16{8'hA5}};
`else
        exp_byp = '0;
`endif
        check("bypass_rs3", rs3Data, exp_byp);
        cyc('0, '0, 1'b0, 1'b0);
        check("bypass_rs3_after", rs3Data, {16{8'hA5}});

        // Stall with a valid R3 in WB
        v_stall = {4{32'h1234_5678}};
        rs2Addr = 5'd7;
        cyc(I_R3_7, v_stall, 1'b1, 1'b0);
        c0 = retireCount;
        for (int i = 0; i < 3; i++) begin
            cyc(I_R4_9, {4{32'hFFFF_0000}}, 1'b1, 1'b1);
            check("stall_instrWB", instructionWB, I_R3_7);
            check("stall_rdWB", rdWB, v_stall);
            check("stall_we", wbWriteEn, 1'b0);
            check("stall_rs2", rs2Data, 128'h0);
            check("stall_count", retireCount, c0);
        end
        cyc('0, '0, 1'b0, 1'b0);
        check("release_rs2", rs2Data, v_stall);
        check("release_count", retireCount, c0 + 32'd1);
        cyc('0, '0, 1'b0, 1'b0);
        check("release_once", retireCount, c0 + 32'd1);

        // Nop retires without writing; bubble neither
        rs1Addr = 5'd3;
        cyc(I_NOP3, {4{32'hDEAD_BEEF}}, 1'b1, 1'b0);
        check("nop_we", wbWriteEn, 1'b0);
        check("nop_valid", validWB, 1'b1);
        cyc('0, '0, 1'b0, 1'b0);
        check("nop_count", retireCount, c0 + 32'd2);
        check("nop_rs1", rs1Data, 128'h0);
        cyc('0, '0, 1'b0, 1'b0);
        check("bubble_valid", validWB, 1'b0);
        check("bubble_count", retireCount, c0 + 32'd2);

        // R4 write, then reset with a pending commit held by stall
        rs1Addr = 5'd5;
        rs2Addr = 5'd9;
        cyc(I_R4_9, {4{32'h0BAD_F00D}}, 1'b1, 1'b0);
        cyc(I_LI5, {4{32'h5555_5555}}, 1'b1, 1'b0);
        check("r4_rs2", rs2Data, {4{32'h0BAD_F00D}});
        cyc('0, '0, 1'b0, 1'b0);
        check("li5_rs1", rs1Data, {4{32'h5555_5555}});
        cyc(I_LI5, {4{32'h6666_6666}}, 1'b1, 1'b0);
        cyc('0, '0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_instrWB", instructionWB, 25'h0);
        check("mrst_rdWB", rdWB, 128'h0);
        check("mrst_validWB", validWB, 1'b0);
        check("mrst_we", wbWriteEn, 1'b0);
        check("mrst_count", retireCount, 32'h0);
        check("mrst_rs1", rs1Data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        check("mrst_dropped", rs1Data, 128'h0);

        // Counter wrap on the 4-bit instance, 32-bit instance keeps counting
        for (int i = 0; i < 15; i++) begin
            rs1Addr = 5'(i);
            rs2Addr = 5'(i + 1);
            rs3Addr = 5'(i + 2);
            cyc({20'h0, 5'(i)}, {4{32'(i * 3 + 1)}}, 1'b1, 1'b0);
        end
        cyc('0, '0, 1'b0, 1'b0);
        check("wrap_pre4", w_cnt, 4'hF);
        check("wrap_pre32", retireCount, 32'd15);
        cyc(I_R3_7, {4{32'h7}}, 1'b1, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        check("wrap_post4", w_cnt, 4'h0);
        check("wrap_post32", retireCount, 32'd16);
        check("wrap_reg2", rs3Data, 128'h0);
        rs3Addr = 5'd14;
        #1;
        check("loop_reg14", rs3Data, {4{32'd43}});
        @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage of the pipelined SIMD unit: holds the EX/WB pipeline register, commits results into the 32 x 128-bit register file, and serves the three ID-stage source reads.
- Producer end of the forwarding path: drives instructionWB/rdWB, which the forwarding unit compares against instructionEX source fields.
- Also counts retired instructions.

Parameters:
- DATA_W, 128, register/result width
- INSTR_W, 25, instruction width
- REG_N, 32, number of registers (address width 5)
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold EX/WB register; no commit
- validEX  in  1  instructionEX/resultEX valid
- instructionEX  in  25  instruction leaving EX
- resultEX  in  128  EX result, already lane-merged
- rs1Addr, rs2Addr, rs3Addr  in  5 each  ID read addresses (instr bits [9:5], [14:10], [19:15])
- rs1Data, rs2Data, rs3Data  out  128 each  read data
- instructionWB  out  25  registered instruction in WB
- rdWB  out  128  registered result in WB
- validWB  out  1  WB slot holds a valid instruction
- wbWriteEn  out  1  WB instruction writes rd this cycle
- retireCount  out  32  committed-instruction count

Behaviour:
- Reset (async, rst_n=0): instructionWB=0, rdWB=0, validWB=0, retireCount=0, all 32 registers=0. Reads return 0 during reset.
- Writes-rd decode on instructionWB:
  - [24]=0: load immediate, writes rd=[4:0].
  - [24:23]=10: R4 multiply-add/sub, writes rd.
  - [24:23]=11 with opcode [22:15]!=8'h00: R3, writes rd.
  - [24:23]=11 with opcode 8'h00: nop, no write.
- wbWriteEn = validWB & writes-rd & !stall. Combinational.
- Commit on the rising edge where wbWriteEn=1: reg[instructionWB[4:0]] <= rdWB.
- Retire on the rising edge where validWB & !stall: retireCount += 1, wrapping 2^32-1 -> 0. Nops retire but do not write.
- EX/WB advance on the rising edge with stall=0: instructionWB <= instructionEX, rdWB <= resultEX, validWB <= validEX.
- stall=1: WB contents held, no commit, no retire. Each instruction commits exactly once regardless of stall length.
- validEX=0 with stall=0: bubble enters, validWB=0. instructionWB/rdWB still load (don't-care contents).
- Read ports are combinational: rsNData = reg[rsNAddr], subject to the optional bypass below.
- All 32 registers are general purpose; register 0 is not hardwired.
- Latency: result visible in the register array 2 edges after it is presented on resultEX (1 edge into WB, 1 edge commit).
- Reset asserted mid-stall or with a pending commit: pending commit is dropped, state returns to reset values.

Optional Feature:
- WB_BYPASS_EN defined: when wbWriteEn=1 and rsNAddr==instructionWB[4:0], rsNData = rdWB in the same cycle (write-through; all three ports independently).
- WB_BYPASS_EN undefined: reads always return the stored array value; the old value is visible until the commit edge.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 immediately; rs1Addr=5 reads 0.
- Basic commit: instructionEX=25'b1100000001011001000111001 ($25=$17+$12), resultEX=4x32'h6, validEX=1 -> after edge 1, instructionWB matches and rdWB=4x32'h6, wbWriteEn=1; after edge 2, rs1Addr=25 reads 4x32'h6 and retireCount=1.
- Bypass: WB holds rd=1 with value 128'hA5..A5, rs3Addr=1 in the same cycle -> with WB_BYPASS_EN, rs3Data=A5..A5 before the commit edge; without it, rs3Data=old value (0).
- Stall: stall=1 for 3 cycles with a valid R3 instruction in WB -> instructionWB/rdWB unchanged, register unchanged, retireCount unchanged; on release, exactly one commit and retireCount +1.
- Nop/bubble: R3 opcode 8'h00 in WB -> wbWriteEn=0, retireCount +1, no register changes. validEX=0 -> validWB=0, no count.
- Counter wrap: force retireCount=32'hFFFFFFFF, retire one -> 0.
